// File: rtl/dna_hex_tx_if.sv
// Handshake/data bundle between the device-ID source and the ID UART transmitter.
interface dna_hex_tx_if;
    logic        dna_rdy;
    logic [56:0] dna_id;
    logic        tx_req;
    logic        uart_txd;
    logic        tx_busy;
    logic        tx_done;

    modport master (output dna_rdy, dna_id, tx_req, input uart_txd, tx_busy, tx_done);
    modport slave  (input dna_rdy, dna_id, tx_req, output uart_txd, tx_busy, tx_done);
endinterface

// File: rtl/dna_hex_tx.sv
// Sends the 57-bit device ID as 15 uppercase hex digits plus CR LF over an 8N1 UART,
// automatically on dna_rdy rising and on request while dna_rdy is high.
module dna_hex_tx #(
    parameter int CLK_DIV = 868
) (
    input  logic          sys_clk,
    input  logic          sys_nrst,
    dna_hex_tx_if.slave   bus
);

    localparam int             CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [4:0]       chr_q, chr_d;
    logic [59:0]      sh_q, sh_d;
    logic             txd_q, txd_d;
    logic             rdy_q;
    logic             trig;
    logic             bit_end;
    logic [7:0]       cur_char;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        else           return 8'h37 + {4'h0, n};
    endfunction

    // Rising edge of dna_rdy, or an explicit request while the ID is valid; only sampled in IDLE.
    assign trig    = (state_q == IDLE) && bus.dna_rdy && (!rdy_q || bus.tx_req);
    assign bit_end = (cnt_q == CNT_MAX);

    // Characters 0..14 take the top nibble of the shift register; 15 and 16 are CR and LF.
    always_comb begin
        if (chr_q == 5'd15)      cur_char = 8'h0D;
        else if (chr_q == 5'd16) cur_char = 8'h0A;
        else                     cur_char = hex_ascii(sh_q[59:56]);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        chr_d   = chr_q;
        sh_d    = sh_q;
        txd_d   = txd_q;
        unique case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                cnt_d = '0;
                if (trig) begin
                    sh_d    = {3'b000, bus.dna_id};
                    chr_d   = '0;
                    bit_d   = '0;
                    txd_d   = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    bit_d   = '0;
                    txd_d   = cur_char[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = cur_char[bit_q + 3'd1];
                    end
                end
            end
            STOP: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    if (chr_q == 5'd16) begin
                        txd_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        chr_d   = chr_q + 5'd1;
                        sh_d    = {sh_q[55:0], 4'h0};
                        txd_d   = 1'b0;
                        state_d = START;
                    end
                end
            end
            DONE: begin
                txd_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                txd_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            chr_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            chr_q   <= chr_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
            rdy_q   <= bus.dna_rdy;
        end
    end

    assign bus.uart_txd = txd_q;
    assign bus.tx_busy  = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    assign bus.tx_done  = (state_q == DONE);

endmodule
